// File: rtl/axi_sram_slave.sv
// AXI-style SRAM responder: independent write (addr then data) and read-burst FSMs over a DEPTH x 64-bit array.
// Optional macro SRAM_WAIT_STATE_EN inserts RD_WAIT idle cycles before the first beat of each read burst.
module axi_sram_slave #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned RD_WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        maxi_wavalid,
  output logic        maxi_waready,
  input  logic [63:0] maxi_waddr,
  input  logic        maxi_wdvalid,
  output logic        maxi_wdready,
  input  logic [63:0] maxi_wdata,
  input  logic [7:0]  maxi_wstrb,
  input  logic        maxi_ravalid,
  output logic        maxi_raready,
  input  logic [63:0] maxi_raddr,
  output logic        maxi_rdvalid,
  input  logic        maxi_rdready,
  output logic [63:0] maxi_rdata,
  output logic        maxi_rlast
);

  localparam int DATA_W = 64;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  // Word index of a byte address; the low IDX_W bits give the modulo-DEPTH wrap.
  function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BASE_ADDR;
    return off[IDX_W+2:3];
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  typedef enum logic {W_IDLE, W_DATA} w_state_t;
  w_state_t         w_state;
  logic [IDX_W-1:0] w_idx;
  logic             w_fire;

`ifdef SRAM_WAIT_STATE_EN
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  logic [WAIT_W-1:0] wait_cnt;
`else
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
`endif
  r_state_t          r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_idx_next;
  logic [BEAT_W-1:0] beat;

  assign w_fire     = (w_state == W_DATA) && maxi_wdvalid && maxi_wdready && !rst;
  assign r_idx_next = r_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state      <= W_IDLE;
      maxi_waready <= 1'b0;
      maxi_wdready <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (maxi_wavalid && maxi_waready) begin
            w_state      <= W_DATA;
            maxi_waready <= 1'b0;
            maxi_wdready <= 1'b1;
          end else begin
            maxi_waready <= 1'b1;
            maxi_wdready <= 1'b0;
          end
        end
        W_DATA: begin
          if (maxi_wdvalid && maxi_wdready) begin
            w_state      <= W_IDLE;
            maxi_waready <= 1'b1;
            maxi_wdready <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((w_state == W_IDLE) && maxi_wavalid && maxi_waready)
      w_idx <= word_idx(maxi_waddr);
  end

  // Array write; a capture of the same word on this edge still sees the old contents.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int i = 0; i < 8; i++) begin
        if (maxi_wstrb[i])
          mem[w_idx][8*i +: 8] <= maxi_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= R_IDLE;
      maxi_raready <= 1'b0;
      maxi_rdvalid <= 1'b0;
      maxi_rlast   <= 1'b0;
      maxi_rdata   <= '0;
      beat         <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (maxi_ravalid && maxi_raready) begin
            r_idx        <= word_idx(maxi_raddr);
            beat         <= '0;
            maxi_raready <= 1'b0;
`ifdef SRAM_WAIT_STATE_EN
            if (RD_WAIT != 0) begin
              r_state  <= R_WAIT;
              wait_cnt <= WAIT_W'(RD_WAIT - 1);
            end else
`endif
            begin
              r_state      <= R_DATA;
              maxi_rdvalid <= 1'b1;
              maxi_rdata   <= mem[word_idx(maxi_raddr)];
              maxi_rlast   <= (LAST_BEAT == '0);
            end
          end else begin
            maxi_raready <= 1'b1;
          end
        end
`ifdef SRAM_WAIT_STATE_EN
        R_WAIT: begin
          if (wait_cnt == '0) begin
            r_state      <= R_DATA;
            maxi_rdvalid <= 1'b1;
            maxi_rdata   <= mem[r_idx];
            maxi_rlast   <= (LAST_BEAT == '0);
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
`endif
        R_DATA: begin
          // A stalled beat keeps its captured word; the next word is fetched only on acceptance.
          if (maxi_rdready) begin
            if (beat == LAST_BEAT) begin
              r_state      <= R_IDLE;
              maxi_rdvalid <= 1'b0;
              maxi_rlast   <= 1'b0;
              maxi_raready <= 1'b1;
            end else begin
              beat       <= beat + 1'b1;
              r_idx      <= r_idx_next;
              maxi_rdata <= mem[r_idx_next];
              maxi_rlast <= ((beat + 1'b1) == LAST_BEAT);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed scenarios plus randomized traffic against an array model.
module tb_axi_sram_slave;

  localparam int          DEPTH   = 1024;
  localparam logic [63:0] BASE    = 64'h8000_0000;
  localparam int          BL      = 4;
  localparam int          RD_WAIT = 2;
`ifdef SRAM_WAIT_STATE_EN
  localparam int EXP_LAT = RD_WAIT + 1;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk, rst;
  logic        wavalid, waready, wdvalid, wdready;
  logic [63:0] waddr, wdata;
  logic [7:0]  wstrb;
  logic        ravalid, raready, rdvalid, rdready, rlast;
  logic [63:0] raddr, rdata;

  axi_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .BURST_LEN(BL), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .rst(rst),
    .maxi_wavalid(wavalid), .maxi_waready(waready), .maxi_waddr(waddr),
    .maxi_wdvalid(wdvalid), .maxi_wdready(wdready), .maxi_wdata(wdata), .maxi_wstrb(wstrb),
    .maxi_ravalid(ravalid), .maxi_raready(raready), .maxi_raddr(raddr),
    .maxi_rdvalid(rdvalid), .maxi_rdready(rdready), .maxi_rdata(rdata), .maxi_rlast(rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] model [DEPTH];
  int          total = 0;
  int          bad = 0;
  logic [63:0] first_beat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BASE;
    return int'((off >> 3) % 64'(DEPTH));
  endfunction

  function automatic logic [63:0] addr_of(input int idx);
    return BASE + 64'(idx) * 64'd8;
  endfunction

  task automatic model_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
    int k;
    k = idx_of(addr);
    for (int i = 0; i < 8; i++)
      if (strb[i]) model[k][8*i +: 8] = data[8*i +: 8];
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input string tag);
    int n;
    wavalid = 1'b1; waddr = addr; n = 0;
    while (waready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_awrdy"}, 64'(waready), 64'd1);
    @(negedge clk);
    wavalid = 1'b0; wdvalid = 1'b1; wdata = data; wstrb = strb; n = 0;
    while (wdready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_wdrdy"}, 64'(wdready), 64'd1);
    @(negedge clk);
    wdvalid = 1'b0;
    model_write(addr, data, strb);
  endtask

  task automatic rd_burst(input logic [63:0] addr, input bit rand_rdy, input int stall_beat,
                          input logic [63:0] sw_data, input string tag);
    int n, b, guard, i0;
    logic [63:0] exp_q [BL];
    i0 = idx_of(addr);
    for (int k = 0; k < BL; k++) exp_q[k] = model[(i0 + k) % DEPTH];
    ravalid = 1'b1; raddr = addr; rdready = 1'b1; n = 0;
    while (raready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_ardy"}, 64'(raready), 64'd1);
    @(negedge clk);
    ravalid = 1'b0; n = 1;
    while (rdvalid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 64'(n), 64'(EXP_LAT));
    b = 0; guard = 0;
    while (b < BL && guard < 200) begin
      guard++;
      chk($sformatf("%s_vld%0d", tag, b), 64'(rdvalid), 64'd1);
      chk($sformatf("%s_dat%0d", tag, b), rdata, exp_q[b]);
      chk($sformatf("%s_lst%0d", tag, b), 64'(rlast), 64'(b == BL - 1));
      if (b == 0) first_beat = rdata;
      if (b == stall_beat) begin
        stall_beat = -1;
        rdready = 1'b0;
        chk({tag, "_stall_awrdy"}, 64'(waready), 64'd1);
        wavalid = 1'b1; waddr = addr_of((i0 + b) % DEPTH);
        @(negedge clk);
        chk({tag, "_hold0"}, rdata, exp_q[b]);
        chk({tag, "_hlst0"}, 64'(rlast), 64'(b == BL - 1));
        wavalid = 1'b0; wdvalid = 1'b1; wdata = sw_data; wstrb = 8'hFF;
        @(negedge clk);
        chk({tag, "_hold1"}, rdata, exp_q[b]);
        chk({tag, "_hvld1"}, 64'(rdvalid), 64'd1);
        wdvalid = 1'b0;
        @(negedge clk);
        chk({tag, "_hold2"}, rdata, exp_q[b]);
        model_write(addr_of((i0 + b) % DEPTH), sw_data, 8'hFF);
      end else begin
        rdready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (rdready) b++;
      end
    end
    rdready = 1'b1;
    chk({tag, "_end_vld"}, 64'(rdvalid), 64'd0);
    chk({tag, "_end_ardy"}, 64'(raready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    wavalid = 1'b0; wdvalid = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    ravalid = 1'b0; raddr = '0; rdready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_waready", 64'(waready), 64'd0);
    chk("rst_wdready", 64'(wdready), 64'd0);
    chk("rst_raready", 64'(raready), 64'd0);
    chk("rst_rdvalid", 64'(rdvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_waready", 64'(waready), 64'd1);
    chk("post_rst_raready", 64'(raready), 64'd1);

    for (int k = 0; k < 20; k++) do_write(addr_of(k), {$urandom, $urandom}, 8'hFF, "init");
    do_write(addr_of(DEPTH - 2), {$urandom, $urandom}, 8'hFF, "init_hi0");
    do_write(addr_of(DEPTH - 1), {$urandom, $urandom}, 8'hFF, "init_hi1");

    // Basic write and burst readback
    do_write(64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, "t1w");
    rd_burst(64'h8000_0008, 1'b0, -1, 64'd0, "t1r");
    chk("t1_beat0", first_beat, 64'h1122_3344_5566_7788);

    // Partial strobes, then an all-zero strobe that must leave the word alone
    do_write(64'h8000_0010, 64'd0, 8'hFF, "t2w0");
    do_write(64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, "t2w1");
    rd_burst(64'h8000_0010, 1'b0, -1, 64'd0, "t2r");
    chk("t2_beat0", first_beat, 64'h0000_0000_FFFF_FFFF);
    do_write(64'h8000_0010, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, "t2w2");
    rd_burst(64'h8000_0010, 1'b0, -1, 64'd0, "t2r2");
    chk("t2_strb0", first_beat, 64'h0000_0000_FFFF_FFFF);

    // Stall on beat 1 with a write to that word; old data returned, next burst sees the new word
    rd_burst(addr_of(4), 1'b0, 1, 64'hCAFE_F00D_0BAD_5EED, "t3r");
    rd_burst(addr_of(5), 1'b0, -1, 64'd0, "t3rb");
    chk("t3_newdata", first_beat, 64'hCAFE_F00D_0BAD_5EED);

    // Wrap at the top of the array, and address aliasing
    rd_burst(addr_of(DEPTH - 2), 1'b0, -1, 64'd0, "t4r");
    do_write(BASE + 64'(8 * DEPTH) + 64'd13, 64'h0123_4567_89AB_CDEF, 8'hFF, "t4alias");
    rd_burst(addr_of(1), 1'b0, -1, 64'd0, "t4ra");
    chk("t4_alias", first_beat, 64'h0123_4567_89AB_CDEF);

    // Read burst and write launched in the same cycle
    begin : t5
      logic [63:0] e5 [BL];
      logic [63:0] wa, wd;
      int n;
      for (int k = 0; k < BL; k++) e5[k] = model[6 + k];
      wa = addr_of(15); wd = {$urandom, $urandom};
      chk("t5_ardy", 64'(raready), 64'd1);
      chk("t5_awrdy", 64'(waready), 64'd1);
      ravalid = 1'b1; raddr = addr_of(6); wavalid = 1'b1; waddr = wa; rdready = 1'b1;
      @(negedge clk);
      ravalid = 1'b0; wavalid = 1'b0; wdvalid = 1'b1; wdata = wd; wstrb = 8'hFF;
      chk("t5_wdrdy", 64'(wdready), 64'd1);
      n = 1;
      while (rdvalid !== 1'b1 && n < 40) begin @(negedge clk); wdvalid = 1'b0; n++; end
      chk("t5_lat", 64'(n), 64'(EXP_LAT));
      for (int b = 0; b < BL; b++) begin
        chk($sformatf("t5_dat%0d", b), rdata, e5[b]);
        chk($sformatf("t5_lst%0d", b), 64'(rlast), 64'(b == BL - 1));
        @(negedge clk);
        wdvalid = 1'b0;
      end
      chk("t5_end_vld", 64'(rdvalid), 64'd0);
      chk("t5_end_awrdy", 64'(waready), 64'd1);
      model_write(wa, wd, 8'hFF);
      rd_burst(wa, 1'b0, -1, 64'd0, "t5rb");
      chk("t5_readback", first_beat, wd);
    end

    // Reset in the middle of a burst
    begin : t6
      int n;
      ravalid = 1'b1; raddr = addr_of(0); rdready = 1'b1; n = 0;
      while (raready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      ravalid = 1'b0; n = 1;
      while (rdvalid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      @(negedge clk);
      @(negedge clk);
      chk("t6_beat2_vld", 64'(rdvalid), 64'd1);
      chk("t6_beat2_dat", rdata, model[2]);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_vld", 64'(rdvalid), 64'd0);
      chk("t6_rst_lst", 64'(rlast), 64'd0);
      chk("t6_rst_dat", rdata, 64'd0);
      chk("t6_rst_ardy", 64'(raready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_ardy", 64'(raready), 64'd1);
      chk("t6_awrdy", 64'(waready), 64'd1);
      chk("t6_vld", 64'(rdvalid), 64'd0);
      rd_burst(addr_of(0), 1'b0, -1, 64'd0, "t6keep");
    end

    // Randomized traffic with random read back-pressure
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(addr_of($urandom_range(0, 19)) | 64'($urandom_range(0, 7)),
                 {$urandom, $urandom}, 8'($urandom), "rndw");
      else
        rd_burst(addr_of($urandom_range(0, 16)) | 64'($urandom_range(0, 7)),
                 1'b1, -1, 64'd0, "rndr");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
